// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  localparam int MAX_LEN = 8;

  // A length of 0 or anything above MAX_LEN sends a full byte.
  function automatic logic [3:0] eff_len(input logic [3:0] cmd_len);
    if (cmd_len == 4'd0 || cmd_len > 4'(MAX_LEN))
      return 4'(MAX_LEN);
    return cmd_len;
  endfunction

endpackage

// File: rtl/seq_tx_tick.sv
// Bit-period timer: bit_end is high in the last clock of each BIT_CYCLES-long period.
module seq_tx_tick #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] tick;

  assign bit_end = (tick == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tick <= '0;
    else if (clear || bit_end)
      tick <= '0;
    else
      tick <= tick + CW'(1);
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serialises a 1..8 bit pattern MSB-first onto X, each bit held BIT_CYCLES clocks,
// followed by GAP_CYCLES bit periods of idle level.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   BIT_CYCLES = 1,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_len,
  output logic       X,
  output logic       x_active,
  output logic       done,
  output logic       busy
);

  tx_state_t  state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic       bit_end;
  logic       tick_clear;
  logic       accept;

  assign accept     = cmd_valid && cmd_ready;
  // Holding the timer at zero while idle aligns bit periods to the accept edge.
  assign tick_clear = (state == TX_IDLE);

  seq_tx_tick #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (tick_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (accept)
      shreg <= cmd_data;
    else if (state == TX_SHIFT && bit_end)
      shreg <= {shreg[6:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      X         <= IDLE_BIT;
      x_active  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (accept) begin
            state     <= TX_SHIFT;
            bit_cnt   <= eff_len(cmd_len);
            X         <= cmd_data[7];
            x_active  <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end
        TX_SHIFT: begin
          if (bit_end) begin
            if (bit_cnt == 4'd1) begin
              X        <= IDLE_BIT;
              x_active <= 1'b0;
              done     <= 1'b1;
              bit_cnt  <= '0;
              // The gap is counted from the done cycle, so the timer keeps running.
              if (GAP_CYCLES > 0) begin
                state   <= TX_GAP;
                gap_cnt <= 4'(GAP_CYCLES);
              end else begin
                state     <= TX_IDLE;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              X       <= shreg[6];
            end
          end
        end
        TX_GAP: begin
          if (bit_end) begin
            if (gap_cnt == 4'd1) begin
              state     <= TX_IDLE;
              gap_cnt   <= '0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
        end
        default: begin
          state     <= TX_IDLE;
          X         <= IDLE_BIT;
          x_active  <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: three parameter sets, each with a queue-based reference model.
`timescale 1ns/1ps
module tb_seq_pattern_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s [dut%0d] t=%0t: got %0d, expected %0d", name, inst, $time, act, req);
    end
  endtask

  function automatic int eff_len_m(input logic [3:0] l);
    return (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int BC = (g == 1) ? 3 : 1;
    localparam int GC = (g == 2) ? 0 : 2;

    logic       rst, cmd_valid, cmd_ready, x, x_active, done, busy;
    logic [7:0] cmd_data;
    logic [3:0] cmd_len;
    bit         fin = 1'b0;

    seq_pattern_tx #(.BIT_CYCLES(BC), .GAP_CYCLES(GC), .IDLE_BIT(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .X         (x),
      .x_active  (x_active),
      .done      (done),
      .busy      (busy)
    );

    // Reference model: expected line bits per clock, plus done/gap bookkeeping.
    bit bit_q[$];
    bit done_pend = 1'b0;
    int gap_left  = 0;
    bit exp_ready, exp_done, exp_active, exp_bit;

    always @(negedge clk) begin
      if (rst) begin
        bit_q.delete();
        done_pend = 1'b0;
        gap_left  = 0;
        chk("rst_X", g, x, 1'b1);
        chk("rst_x_active", g, x_active, 1'b0);
        chk("rst_busy", g, busy, 1'b0);
        chk("rst_cmd_ready", g, cmd_ready, 1'b1);
        chk("rst_done", g, done, 1'b0);
      end else begin
        exp_done  = done_pend;
        done_pend = 1'b0;
        if (exp_done) begin
          exp_ready = (GC == 0);
          gap_left  = (GC > 0) ? GC * BC - 1 : 0;
        end else if (gap_left > 0) begin
          exp_ready = 1'b0;
          gap_left--;
        end else begin
          exp_ready = (bit_q.size() == 0);
        end
        exp_active = (bit_q.size() != 0);
        chk("x_active", g, x_active, exp_active);
        chk("done", g, done, exp_done);
        chk("cmd_ready", g, cmd_ready, exp_ready);
        chk("busy", g, busy, !exp_ready);
        if (exp_active) begin
          exp_bit = bit_q.pop_front();
          chk("X_bit", g, x, exp_bit);
          if (bit_q.size() == 0) done_pend = 1'b1;
        end else begin
          chk("X_idle", g, x, 1'b1);
        end
        if (exp_ready && cmd_valid) begin
          for (int i = 0; i < eff_len_m(cmd_len); i++)
            for (int j = 0; j < BC; j++)
              bit_q.push_back(cmd_data[7-i]);
        end
      end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] l);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_len   = l;
      do begin
        @(negedge clk);
        w++;
      end while (!cmd_ready && w < 300);
      if (!cmd_ready) chk("accept_timeout", g, cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!cmd_ready && w < 300);
      if (!cmd_ready) chk("idle_timeout", g, cmd_ready, 1'b1);
      @(posedge clk);
      #1;
    endtask

    initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_len   = '0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      send(8'b0100_0000, 4'd3);
      wait_idle();
      send(8'b1000_0000, 4'd2);
      wait_idle();
      send(8'hA5, 4'd0);
      wait_idle();
      send(8'b1100_0000, 4'd2);
      send(8'b0000_0000, 4'd1);
      wait_idle();

      // Commands offered while busy must be ignored.
      send(8'h3C, 4'd8);
      cmd_valid = 1'b1;
      cmd_data  = 8'hFF;
      cmd_len   = 4'd1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of a bit.
      send(8'h96, 4'd8);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_X", g, x, 1'b1);
      chk("async_rst_x_active", g, x_active, 1'b0);
      chk("async_rst_busy", g, busy, 1'b0);
      chk("async_rst_cmd_ready", g, cmd_ready, 1'b1);
      chk("async_rst_done", g, done, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      send(8'h80, 4'd1);
      wait_idle();

      for (int i = 0; i < 25; i++) begin
        send(8'($urandom), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
        end
      end
      wait_idle();
      repeat (3) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int w = 0;
    while (!(inst[0].fin && inst[1].fin && inst[2].fin) && w < 50000) begin
      @(posedge clk);
      w++;
    end
    chk("run_complete", 0, {31'd0, inst[0].fin && inst[1].fin && inst[2].fin}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit serial line X consumed by the team's serial pattern detectors (Z1/Z2 style FSMs). It accepts a short bit pattern over a valid/ready command interface and serialises it MSB-first onto X. Each bit is held for a programmable number of clocks. Between patterns the line is filled with a fixed idle level, and a guaranteed inter-pattern gap is enforced. It is the source end of the detector's input stream, used both in-system and as the canonical stimulus generator in detector benches.

Parameters:
BIT_CYCLES, 1, clocks each serial bit is held on X (1..16)
GAP_CYCLES, 2, bit periods of idle level inserted after every pattern (0..15)
IDLE_BIT, 1'b1, level driven on X when not transmitting

Ports:
clk  input  1  system clock, all state changes on posedge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  transmitter can accept a command this cycle
cmd_data  input  8  pattern bits, MSB transmitted first
cmd_len  input  4  number of bits to send, 1..8; 0 or >8 treated as 8
X  output  1  serial line, registered
x_active  output  1  high while X carries pattern bits (not idle/gap)
done  output  1  one-cycle pulse after the last bit period of a pattern completes
busy  output  1  high from command accept until return to IDLE

Behaviour:
- Reset (async, any time incl. mid-pattern): X=IDLE_BIT, x_active=0, done=0, busy=0, cmd_ready=1, state=TX_IDLE, all counters 0. The in-flight pattern is discarded, not resumed.
- FSM states: TX_IDLE, TX_SHIFT, TX_GAP.
- TX_IDLE:
  - cmd_ready=1; X=IDLE_BIT.
  - When cmd_valid&&cmd_ready is high at an edge: latch cmd_data into the shift register and the effective length into bit_cnt; go to TX_SHIFT. cmd_ready drops the cycle after.
  - X = cmd_data[7] from that same edge. The first pattern bit is visible the cycle after accept (latency 1).
- TX_SHIFT:
  - Each bit is held exactly BIT_CYCLES clocks; a tick counter runs 0..BIT_CYCLES-1.
  - At the end of each bit period: shift left, decrement bit_cnt, drive the next bit.
  - After the last bit period: X=IDLE_BIT, x_active=0, done=1 for exactly one cycle.
    - GAP_CYCLES>0: go to TX_GAP.
    - GAP_CYCLES=0: go to TX_IDLE.
  - x_active=1 for exactly len*BIT_CYCLES consecutive cycles.
- TX_GAP:
  - X=IDLE_BIT for GAP_CYCLES*BIT_CYCLES clocks, counted from the cycle done pulses; then go to TX_IDLE.
  - cmd_ready=0 throughout.
- cmd_valid while not ready is ignored. There is no buffering; the source must hold the command until accepted.
- Back-to-back commands with GAP_CYCLES=0: the next accept can occur in the cycle done is high, because the state is TX_IDLE then. The first bit of the new pattern follows one cycle later, so there is always at least one idle-level cycle between patterns.
- cmd_data bits below the effective length are ignored.
- busy = (state != TX_IDLE).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package seq_tx_pkg holds:
  - typedef enum logic [1:0] tx_state_t {TX_IDLE, TX_SHIFT, TX_GAP}
  - localparam MAX_LEN = 8
  - function eff_len(cmd_len), mapping 0 and values >8 to 8
- One sub-module, seq_tx_tick: a parameterised BIT_CYCLES counter with inputs clk, rst, clear, and a one-cycle output bit_end. It is shared by the shift and gap phases.

Test Plan:
1. Reset, defaults (BIT_CYCLES=1, GAP_CYCLES=2, IDLE_BIT=1); accept cmd_data=8'b0100_0000, cmd_len=3 at cycle 0 -> X=0,1,0 on cycles 1..3; x_active high cycles 1..3; done pulse cycle 4; X=1 cycles 4..5; cmd_ready=1 again cycle 6.
2. BIT_CYCLES=3, cmd_data=8'b1000_0000, cmd_len=2 -> X=1 cycles 1..3, X=0 cycles 4..6; done at cycle 7; busy high cycles 1..12.
3. cmd_len=0 with cmd_data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; x_active high exactly 8 cycles.
4. GAP_CYCLES=0, cmd_valid held high with two commands (8'b1100_0000/len 2, then 8'b0000_0000/len 1) -> second accept in the done cycle; X sequence 1,1,(idle 1),0; exactly one idle cycle between patterns.
5. Assert rst asynchronously mid-bit during an 8-bit pattern -> X=1, x_active=0, busy=0, cmd_ready=1 immediately, without waiting for a clock edge; no done pulse; the next command transmits from its MSB.
6. cmd_valid pulsed while busy -> ignored; no change to X and no extra done pulse.
